// File: rtl/control_types_pkg.sv
// Control encodings shared by the decoder and every pipeline register.
package control_types_pkg;

  // Writeback source select; WB_ALU doubles as the bubble encoding.
  typedef enum logic [1:0] {
    WB_ALU      = 2'd0,
    WB_MEM      = 2'd1,
    WB_PC_PLUS4 = 2'd2
  } reg_wr_src_t;

  // Data-memory access type/size; MEM_NONE doubles as the bubble encoding.
  typedef enum logic [3:0] {
    MEM_NONE = 4'd0,
    MEM_LB   = 4'd1,
    MEM_LH   = 4'd2,
    MEM_LW   = 4'd3,
    MEM_LBU  = 4'd4,
    MEM_LHU  = 4'd5,
    MEM_SB   = 4'd6,
    MEM_SH   = 4'd7,
    MEM_SW   = 4'd8
  } mem_op_t;

endpackage : control_types_pkg

// File: rtl/ex_mem_register_pkg.sv
// Widths and payload layout of the EX->MEM pipeline register.
package ex_mem_register_pkg;

  import control_types_pkg::*;

  localparam int unsigned EX_MEM_XLEN      = 32;
  localparam int unsigned EX_MEM_REG_IDX_W = 5;

  // Everything the MEM stage needs from EX, held as one flop vector.
  typedef struct packed {
    logic                          reg_do_write;
    reg_wr_src_t                   reg_wr_src;
    logic                          mem_do_write;
    mem_op_t                       mem_ctrl;
    logic [EX_MEM_XLEN-1:0]        pc_plus4;
    logic [EX_MEM_XLEN-1:0]        alu_result;
    logic [EX_MEM_XLEN-1:0]        mem_data_in;
    logic [EX_MEM_REG_IDX_W-1:0]   wr_reg_idx;
  } ex_mem_bus_t;

  // All-zero payload: no register write, no memory access, destination x0.
  localparam ex_mem_bus_t EX_MEM_BUBBLE = '0;

endpackage : ex_mem_register_pkg

// File: rtl/ex_mem_register.sv
// EX->MEM pipeline register with hazard-unit flush (clear) and stall (enable low).
// The payload struct is laid out with the package widths, so XLEN/REG_IDX_W
// are expected to stay at their package defaults.
module ex_mem_register
  import control_types_pkg::*;
  import ex_mem_register_pkg::*;
#(
  parameter int unsigned XLEN      = EX_MEM_XLEN,
  parameter int unsigned REG_IDX_W = EX_MEM_REG_IDX_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 enable,
  input  logic                 reg_do_write_ctrl_ex,
  input  reg_wr_src_t          reg_wr_src_ctrl_ex,
  input  logic                 mem_do_write_ctrl_ex,
  input  mem_op_t              mem_ctrl_ex,
  input  logic [XLEN-1:0]      pc_plus4_ex,
  input  logic [XLEN-1:0]      alu_result_ex,
  input  logic [XLEN-1:0]      mem_data_in_ex,
  input  logic [REG_IDX_W-1:0] wr_reg_idx_ex,
  output logic                 reg_do_write_ctrl_mem,
  output reg_wr_src_t          reg_wr_src_ctrl_mem,
  output logic                 mem_do_write_ctrl_mem,
  output mem_op_t              mem_ctrl_mem,
  output logic [XLEN-1:0]      pc_plus4_mem,
  output logic [XLEN-1:0]      alu_result_mem,
  output logic [XLEN-1:0]      mem_data_in_mem,
  output logic [REG_IDX_W-1:0] wr_reg_idx_mem
);

  ex_mem_bus_t ex_bus;
  ex_mem_bus_t stage_d;
  ex_mem_bus_t stage_q;

  // Gather the EX-stage fields into the payload struct.
  always_comb begin
    ex_bus              = EX_MEM_BUBBLE;
    ex_bus.reg_do_write = reg_do_write_ctrl_ex;
    ex_bus.reg_wr_src   = reg_wr_src_ctrl_ex;
    ex_bus.mem_do_write = mem_do_write_ctrl_ex;
    ex_bus.mem_ctrl     = mem_ctrl_ex;
    ex_bus.pc_plus4     = pc_plus4_ex;
    ex_bus.alu_result   = alu_result_ex;
    ex_bus.mem_data_in  = mem_data_in_ex;
    ex_bus.wr_reg_idx   = wr_reg_idx_ex;
  end

  // Next payload: flush beats stall so a bubble still enters a held stage.
  always_comb begin
    stage_d = stage_q;
    if (clear) begin
      stage_d = EX_MEM_BUBBLE;
    end else if (enable) begin
      stage_d = ex_bus;
    end
  end

  // Stage flops with synchronous active-low reset to the bubble.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stage_q <= EX_MEM_BUBBLE;
    end else begin
      stage_q <= stage_d;
    end
  end

  // Present the held payload to the MEM stage.
  assign reg_do_write_ctrl_mem = stage_q.reg_do_write;
  assign reg_wr_src_ctrl_mem   = stage_q.reg_wr_src;
  assign mem_do_write_ctrl_mem = stage_q.mem_do_write;
  assign mem_ctrl_mem          = stage_q.mem_ctrl;
  assign pc_plus4_mem          = stage_q.pc_plus4;
  assign alu_result_mem        = stage_q.alu_result;
  assign mem_data_in_mem       = stage_q.mem_data_in;
  assign wr_reg_idx_mem        = stage_q.wr_reg_idx;

endmodule : ex_mem_register

// File: tb/tb_ex_mem_register.sv
// Directed plus randomized bench for the EX->MEM pipeline register.
module tb_ex_mem_register;

  import control_types_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        clear;
  logic        enable;
  logic        reg_do_write_ctrl_ex;
  reg_wr_src_t reg_wr_src_ctrl_ex;
  logic        mem_do_write_ctrl_ex;
  mem_op_t     mem_ctrl_ex;
  logic [31:0] pc_plus4_ex;
  logic [31:0] alu_result_ex;
  logic [31:0] mem_data_in_ex;
  logic [4:0]  wr_reg_idx_ex;
  logic        reg_do_write_ctrl_mem;
  reg_wr_src_t reg_wr_src_ctrl_mem;
  logic        mem_do_write_ctrl_mem;
  mem_op_t     mem_ctrl_mem;
  logic [31:0] pc_plus4_mem;
  logic [31:0] alu_result_mem;
  logic [31:0] mem_data_in_mem;
  logic [4:0]  wr_reg_idx_mem;

  // Reference model: the last value the MEM stage should be showing, per field.
  logic [31:0] exp_f [8];

  int n_checks;
  int n_fail;

  ex_mem_register dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .clear                 (clear),
    .enable                (enable),
    .reg_do_write_ctrl_ex  (reg_do_write_ctrl_ex),
    .reg_wr_src_ctrl_ex    (reg_wr_src_ctrl_ex),
    .mem_do_write_ctrl_ex  (mem_do_write_ctrl_ex),
    .mem_ctrl_ex           (mem_ctrl_ex),
    .pc_plus4_ex           (pc_plus4_ex),
    .alu_result_ex         (alu_result_ex),
    .mem_data_in_ex        (mem_data_in_ex),
    .wr_reg_idx_ex         (wr_reg_idx_ex),
    .reg_do_write_ctrl_mem (reg_do_write_ctrl_mem),
    .reg_wr_src_ctrl_mem   (reg_wr_src_ctrl_mem),
    .mem_do_write_ctrl_mem (mem_do_write_ctrl_mem),
    .mem_ctrl_mem          (mem_ctrl_mem),
    .pc_plus4_mem          (pc_plus4_mem),
    .alu_result_mem        (alu_result_mem),
    .mem_data_in_mem       (mem_data_in_mem),
    .wr_reg_idx_mem        (wr_reg_idx_mem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Snapshot of the inputs as the eight fields, in output order.
  function automatic void sample_inputs(output logic [31:0] f [8]);
    f[0] = 32'(reg_do_write_ctrl_ex);
    f[1] = 32'(reg_wr_src_ctrl_ex);
    f[2] = 32'(mem_do_write_ctrl_ex);
    f[3] = 32'(mem_ctrl_ex);
    f[4] = pc_plus4_ex;
    f[5] = alu_result_ex;
    f[6] = mem_data_in_ex;
    f[7] = 32'(wr_reg_idx_ex);
  endfunction

  // Apply the edge rules: reset, then flush, then capture, else hold.
  task automatic clock_and_model();
    logic [31:0] in_f [8];
    sample_inputs(in_f);
    @(posedge clk);
    if (!rst_n || clear) begin
      for (int i = 0; i < 8; i++) exp_f[i] = 32'd0;
    end else if (enable) begin
      for (int i = 0; i < 8; i++) exp_f[i] = in_f[i];
    end
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".reg_do_write"}, 32'(reg_do_write_ctrl_mem), exp_f[0]);
    check({tag, ".reg_wr_src"},   32'(reg_wr_src_ctrl_mem),   exp_f[1]);
    check({tag, ".mem_do_write"}, 32'(mem_do_write_ctrl_mem), exp_f[2]);
    check({tag, ".mem_ctrl"},     32'(mem_ctrl_mem),          exp_f[3]);
    check({tag, ".pc_plus4"},     pc_plus4_mem,               exp_f[4]);
    check({tag, ".alu_result"},   alu_result_mem,             exp_f[5]);
    check({tag, ".mem_data_in"},  mem_data_in_mem,            exp_f[6]);
    check({tag, ".wr_reg_idx"},   32'(wr_reg_idx_mem),        exp_f[7]);
  endtask

  task automatic randomize_payload();
    reg_do_write_ctrl_ex = 1'($urandom);
    reg_wr_src_ctrl_ex   = reg_wr_src_t'(2'($urandom_range(0, 2)));
    mem_do_write_ctrl_ex = 1'($urandom);
    mem_ctrl_ex          = mem_op_t'(4'($urandom_range(0, 8)));
    pc_plus4_ex          = $urandom;
    alu_result_ex        = $urandom;
    mem_data_in_ex       = $urandom;
    wr_reg_idx_ex        = 5'($urandom);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    for (int i = 0; i < 8; i++) exp_f[i] = 32'd0;

    // Drive every input before the first edge.
    rst_n                = 1'b0;
    clear                = 1'b0;
    enable               = 1'b1;
    reg_do_write_ctrl_ex = 1'b1;
    reg_wr_src_ctrl_ex   = WB_PC_PLUS4;
    mem_do_write_ctrl_ex = 1'b1;
    mem_ctrl_ex          = MEM_SW;
    pc_plus4_ex          = 32'hFFFF_FFFF;
    alu_result_ex        = 32'h1234_5678;
    mem_data_in_ex       = 32'h5555_5555;
    wr_reg_idx_ex        = 5'd31;
    @(negedge clk);

    // Reset beats enable.
    clock_and_model();
    check_model("reset");
    check("reset.mem_ctrl_none", 32'(mem_ctrl_mem), 32'(MEM_NONE));
    check("reset.pc_zero", pc_plus4_mem, 32'd0);

    // Clear with enable high still produces the bubble.
    @(negedge clk);
    rst_n = 1'b1;
    clear = 1'b1;
    clock_and_model();
    check_model("clear");
    check("clear.pc_zero", pc_plus4_mem, 32'd0);

    // Plain latch.
    @(negedge clk);
    clear                = 1'b0;
    reg_do_write_ctrl_ex = 1'b1;
    reg_wr_src_ctrl_ex   = WB_MEM;
    mem_do_write_ctrl_ex = 1'b0;
    mem_ctrl_ex          = MEM_LW;
    pc_plus4_ex          = 32'h0000_1004;
    alu_result_ex        = 32'hAAAA_AAAA;
    mem_data_in_ex       = 32'h0;
    wr_reg_idx_ex        = 5'd5;
    clock_and_model();
    check_model("latch");
    check("latch.alu", alu_result_mem, 32'hAAAA_AAAA);
    check("latch.rd", 32'(wr_reg_idx_mem), 32'd5);
    check("latch.src", 32'(reg_wr_src_ctrl_mem), 32'(WB_MEM));
    check("latch.mem_ctrl", 32'(mem_ctrl_mem), 32'(MEM_LW));

    // Stall holds the previous payload.
    @(negedge clk);
    enable        = 1'b0;
    alu_result_ex = 32'hBBBB_BBBB;
    wr_reg_idx_ex = 5'd10;
    clock_and_model();
    check_model("stall");
    check("stall.alu", alu_result_mem, 32'hAAAA_AAAA);
    check("stall.rd", 32'(wr_reg_idx_mem), 32'd5);

    // Resume captures the stalled inputs.
    @(negedge clk);
    enable = 1'b1;
    clock_and_model();
    check_model("resume");
    check("resume.alu", alu_result_mem, 32'hBBBB_BBBB);
    check("resume.rd", 32'(wr_reg_idx_mem), 32'd10);

    // Flush during stall inserts the bubble.
    @(negedge clk);
    clear  = 1'b1;
    enable = 1'b0;
    clock_and_model();
    check_model("flush_stall");
    check("flush_stall.alu", alu_result_mem, 32'd0);
    check("flush_stall.reg_wr", 32'(reg_do_write_ctrl_mem), 32'd0);

    // Store payload after the flush.
    @(negedge clk);
    clear                = 1'b0;
    enable               = 1'b1;
    mem_data_in_ex       = 32'hDEAD_BEEF;
    mem_do_write_ctrl_ex = 1'b1;
    mem_ctrl_ex          = MEM_SW;
    clock_and_model();
    check_model("store");
    check("store.data", mem_data_in_mem, 32'hDEAD_BEEF);
    check("store.mem_wr", 32'(mem_do_write_ctrl_mem), 32'd1);

    // Mid-operation reset with clear low and enable high.
    @(negedge clk);
    rst_n = 1'b0;
    clock_and_model();
    check_model("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    alu_result_ex = 32'hCAFE_F00D;
    clock_and_model();
    check_model("after_reset");
    check("after_reset.alu", alu_result_mem, 32'hCAFE_F00D);

    // Randomized traffic against the model.
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      randomize_payload();
      rst_n  = ($urandom_range(0, 19) != 0);
      clear  = ($urandom_range(0, 7) == 0);
      enable = ($urandom_range(0, 3) != 0);
      clock_and_model();
      check_model("random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_ex_mem_register

// File: doc/ex_mem_register.md
Name: ex_mem_register

Overview:
- EX→MEM pipeline register of the 5-stage RISC-V core.
- On each rising clk edge it captures EX-stage control and data: writeback control, memory control, PC+4, ALU result, store data and destination register index.
- It presents the captured values to the MEM stage.
- Supports flush (clear) and stall (enable low) from the hazard unit.

Parameters:
- XLEN, 32, data path width for pc_plus4, alu_result and mem_data_in.
- REG_IDX_W, 5, register index width.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- clear  input  1  synchronous flush, active-high; loads the bubble
- enable  input  1  1 = latch new inputs; 0 = hold (stall)
- reg_do_write_ctrl_ex  input  1  register-file write enable from EX
- reg_wr_src_ctrl_ex  input  reg_wr_src_t  writeback source select
- mem_do_write_ctrl_ex  input  1  data-memory write enable
- mem_ctrl_ex  input  mem_op_t  memory access type/size
- pc_plus4_ex  input  XLEN  PC+4 of the instruction
- alu_result_ex  input  XLEN  ALU result / memory address
- mem_data_in_ex  input  XLEN  store data
- wr_reg_idx_ex  input  REG_IDX_W  destination register index
- reg_do_write_ctrl_mem, reg_wr_src_ctrl_mem, mem_do_write_ctrl_mem, mem_ctrl_mem, pc_plus4_mem, alu_result_mem, mem_data_in_mem, wr_reg_idx_mem  output  same widths as the matching _ex inputs  registered copies for the MEM stage

Behaviour:
- All outputs are flops updated only on the rising edge of clk. There is no combinational path from inputs to outputs.
- Priority at each edge, highest first:
  - rst_n = 0: all outputs go to 0.
  - else clear = 1: all outputs go to 0. Clear wins over enable, so a flush during a stall still inserts the bubble.
  - else enable = 1: every output takes its _ex input.
  - else: every output holds its value.
- The all-zero bubble means:
  - reg_do_write_ctrl_mem = 0 and mem_do_write_ctrl_mem = 0.
  - mem_ctrl_mem = MEM_NONE (encoding 0).
  - reg_wr_src_ctrl_mem = WB_ALU (encoding 0).
  - All data fields and wr_reg_idx_mem = 0 (x0).
  - A bubble therefore produces no architectural side effect.
- Latency: exactly one cycle from _ex input to _mem output when enabled.
- X/unknown inputs are captured as-is when enable = 1. Bench stimulus must drive every input before enabling.
- Reset mid-operation: the next edge with rst_n = 0 zeroes all outputs regardless of clear or enable. Normal latching resumes on the first edge after rst_n returns to 1.
- Before the first reset or clear edge, output values are unspecified.

Decomposition:
- Package control_types_pkg (shared with decoder and the other pipeline registers) holds:
  - reg_wr_src_t: 2-bit enum. WB_ALU = 0, WB_MEM = 1, WB_PC_PLUS4 = 2.
  - mem_op_t: 4-bit enum. MEM_NONE = 0, MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU, MEM_SB, MEM_SH, MEM_SW.
- The block is implemented flat as one always_ff over a packed struct of all fields. No sub-module.

Test Plan:
- Reset: rst_n = 0, enable = 1, pc_plus4_ex = FFFFFFFF, alu_result_ex = 12345678; one edge → all outputs 0, mem_ctrl_mem = MEM_NONE.
- Clear: rst_n = 1, clear = 1, enable = 1, pc_plus4_ex = FFFFFFFF; one edge → pc_plus4_mem = 0 and all other outputs 0.
- Latch: clear = 0, enable = 1, reg_do_write_ctrl_ex = 1, alu_result_ex = AAAAAAAA, wr_reg_idx_ex = 5, reg_wr_src_ctrl_ex = WB_MEM, mem_ctrl_ex = MEM_LW; after the edge → alu_result_mem = AAAAAAAA, wr_reg_idx_mem = 5, reg_do_write_ctrl_mem = 1, reg_wr_src_ctrl_mem = WB_MEM, mem_ctrl_mem = MEM_LW.
- Stall: enable = 0, alu_result_ex = BBBBBBBB, wr_reg_idx_ex = 10; after the edge → outputs still AAAAAAAA / 5.
- Resume: enable = 1 with the inputs from the stall step; after the edge → alu_result_mem = BBBBBBBB, wr_reg_idx_mem = 10.
- Flush during stall: outputs holding BBBBBBBB; clear = 1, enable = 0; after the edge → all outputs 0. Then clear = 0, enable = 1, mem_data_in_ex = DEADBEEF, mem_do_write_ctrl_ex = 1; after the next edge → mem_data_in_mem = DEADBEEF, mem_do_write_ctrl_mem = 1.
